// File: rtl/bcp_pkg.sv
// ---------------------------------------------------------------------------
// bcp_pkg
// Shared types and default sizes for the BCP implication queue.
//   bcp_impq_state_e : queue controller state (RUN accepts/applies, HALT
//                      freezes everything after a conflict)
//   bcp_imp_t        : one queued implication {variable index, forced value}
//   BCP_VAR_NUM / BCP_DEPTH / BCP_IDX_W : default sizes
// ---------------------------------------------------------------------------
package bcp_pkg;

    localparam int BCP_VAR_NUM = 8;
    localparam int BCP_DEPTH   = 8;
    localparam int BCP_IDX_W   = $clog2(BCP_VAR_NUM);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } bcp_impq_state_e;

    // "var" is a reserved word, so the index field is var_idx.
    typedef struct packed {
        logic [BCP_IDX_W-1:0] var_idx;
        logic                 value;
    } bcp_imp_t;

endpackage

// File: rtl/bcp_sync_fifo.sv
// ---------------------------------------------------------------------------
// bcp_sync_fifo
// Small synchronous FIFO of implications. Head entry is visible on dout
// combinationally so an entry written at one edge can be popped at the next.
// Ports:
//   clk, srst        : clock, synchronous active-high reset (empties FIFO)
//   push, din        : write request/data (ignored when full)
//   pop, dout        : read request (ignored when empty) / head entry
//   full, empty      : occupancy flags
//   count            : occupancy, 0..DEPTH
// Pointers are $clog2(DEPTH) wide and wrap naturally (DEPTH is a power of
// two); the count is kept separately so full and empty are unambiguous.
// ---------------------------------------------------------------------------
module bcp_sync_fifo
    import bcp_pkg::*;
#(
    parameter type T     = bcp_imp_t,
    parameter int  DEPTH = BCP_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  T                 din,
    input  logic             pop,
    output T                 dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    assign do_push = push & ~full & ~srst;
    assign do_pop  = pop & ~empty & ~srst;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/bcp_implication_queue.sv
// ---------------------------------------------------------------------------
// bcp_implication_queue
// Collects unit implications from the clause checkers, drops duplicates,
// flags conflicting implications (sticky, halts the queue), buffers the
// rest and applies one per cycle to the assignment/free vectors.
// Ports:
//   clock, reset, clear       : clock; sync active-high reset; clear = reset
//   imp_valid/imp_var/imp_value/imp_ready : implication handshake
//   assignment, free          : solver variable state (free=1 -> unassigned)
//   apply_valid, apply_var    : pulse after each applied implication
//   conflict, conflict_var    : sticky conflict and offending variable
//   busy, q_count             : FIFO non-empty / occupancy
//   stat_applied, stat_dropped: saturating counters, only when the macro
//                               BCP_IMPQ_STATS_EN is defined
// ---------------------------------------------------------------------------
module bcp_implication_queue
    import bcp_pkg::*;
#(
    parameter int VAR_NUM = BCP_VAR_NUM,
    parameter int IDX_W   = $clog2(VAR_NUM),
    parameter int DEPTH   = BCP_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   imp_valid,
    input  logic [IDX_W-1:0]       imp_var,
    input  logic                   imp_value,
    output logic                   imp_ready,
    output logic [VAR_NUM-1:0]     assignment,
    output logic [VAR_NUM-1:0]     free,
    output logic                   apply_valid,
    output logic [IDX_W-1:0]       apply_var,
    output logic                   conflict,
    output logic [IDX_W-1:0]       conflict_var,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] q_count
`ifdef BCP_IMPQ_STATS_EN
    ,
    output logic [15:0]            stat_applied,
    output logic [15:0]            stat_dropped
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [IDX_W-1:0] var_idx;
        logic             value;
    } imp_t;

    logic               srst;
    bcp_impq_state_e    state_reg, state_next;
    logic [VAR_NUM-1:0] assignment_reg, free_reg;
    logic [VAR_NUM-1:0] pending_mask_reg, pending_val_reg;
    logic               apply_valid_reg;
    logic [IDX_W-1:0]   apply_var_reg;
    logic               conflict_reg;
    logic [IDX_W-1:0]   conflict_var_reg;

    imp_t               head, push_data;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               in_range, accept, dup_hit, conf_hit;
    logic               enq, drop_dup, conf_now, pop;

    assign srst = reset | clear;

    // Indices past VAR_NUM can only occur when VAR_NUM is not a power of two.
    generate
        if (VAR_NUM >= (1 << IDX_W)) begin : g_range_full
            assign in_range = 1'b1;
        end else begin : g_range_part
            assign in_range = ({1'b0, imp_var} < (IDX_W+1)'(VAR_NUM));
        end
    endgenerate

    // Filtering uses pre-edge state, so an implication on the variable being
    // popped this cycle still sees it as pending.
    assign dup_hit  = (~free_reg[imp_var] & (assignment_reg[imp_var] == imp_value))
                    | (pending_mask_reg[imp_var] & (pending_val_reg[imp_var] == imp_value));
    assign conf_hit = (~free_reg[imp_var] & (assignment_reg[imp_var] != imp_value))
                    | (pending_mask_reg[imp_var] & (pending_val_reg[imp_var] != imp_value));

    assign imp_ready = (state_reg == RUN) & ~fifo_full;
    assign accept    = imp_valid & imp_ready;
    assign conf_now  = accept & in_range & conf_hit;
    assign drop_dup  = accept & in_range & dup_hit & ~conf_hit;
    assign enq       = accept & in_range & ~dup_hit & ~conf_hit;
    // The queue freezes on the conflict edge itself: the pending head is not
    // applied, leaving the vectors exactly as they were when the clash arrived.
    assign pop       = (state_reg == RUN) & ~fifo_empty & ~conf_now;

    assign push_data.var_idx = imp_var;
    assign push_data.value   = imp_value;

    bcp_sync_fifo #(
        .T     (imp_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clock),
        .srst  (srst),
        .push  (enq),
        .din   (push_data),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (conf_now) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (srst) begin
            state_reg        <= RUN;
            assignment_reg   <= '0;
            free_reg         <= '1;
            pending_mask_reg <= '0;
            pending_val_reg  <= '0;
            apply_valid_reg  <= 1'b0;
            apply_var_reg    <= '0;
            conflict_reg     <= 1'b0;
            conflict_var_reg <= '0;
        end else begin
            state_reg       <= state_next;
            apply_valid_reg <= pop;
            if (pop) begin
                assignment_reg[head.var_idx]   <= head.value;
                free_reg[head.var_idx]         <= 1'b0;
                pending_mask_reg[head.var_idx] <= 1'b0;
                apply_var_reg                  <= head.var_idx;
            end
            // A pushed variable is never the popped one (that would be a
            // duplicate or conflict), so these writes cannot collide.
            if (enq) begin
                pending_mask_reg[imp_var] <= 1'b1;
                pending_val_reg[imp_var]  <= imp_value;
            end
            if (conf_now) begin
                conflict_reg     <= 1'b1;
                conflict_var_reg <= imp_var;
            end
        end
    end

    assign assignment   = assignment_reg;
    assign free         = free_reg;
    assign apply_valid  = apply_valid_reg;
    assign apply_var    = apply_var_reg;
    assign conflict     = conflict_reg;
    assign conflict_var = conflict_var_reg;
    assign busy         = ~fifo_empty;
    assign q_count      = fifo_count;

`ifdef BCP_IMPQ_STATS_EN
    logic [15:0] stat_applied_reg, stat_dropped_reg;

    always_ff @(posedge clock) begin
        if (srst) begin
            stat_applied_reg <= '0;
            stat_dropped_reg <= '0;
        end else begin
            if (pop && stat_applied_reg != 16'hFFFF) begin
                stat_applied_reg <= stat_applied_reg + 16'd1;
            end
            if (drop_dup && stat_dropped_reg != 16'hFFFF) begin
                stat_dropped_reg <= stat_dropped_reg + 16'd1;
            end
        end
    end

    assign stat_applied = stat_applied_reg;
    assign stat_dropped = stat_dropped_reg;
`else
    logic unused_drop;
    assign unused_drop = drop_dup;
`endif

endmodule

// File: tb/tb_bcp_implication_queue.sv
// ---------------------------------------------------------------------------
// tb_bcp_implication_queue
// Table of {inputs, expected outputs} rows applied one clock each, followed
// by hand-written sequences for streaming and reset-with-queued-entry.
// Stat counters are compared only when BCP_IMPQ_STATS_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcp_implication_queue;

    logic       clock = 1'b0;
    logic       reset, clear, imp_valid, imp_value;
    logic [2:0] imp_var;
    logic       imp_ready, apply_valid, conflict, busy;
    logic [7:0] assignment, free;
    logic [2:0] apply_var, conflict_var;
    logic [3:0] q_count;
`ifdef BCP_IMPQ_STATS_EN
    logic [15:0] stat_applied, stat_dropped;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    bcp_implication_queue dut (
        .clock        (clock),
        .reset        (reset),
        .clear        (clear),
        .imp_valid    (imp_valid),
        .imp_var      (imp_var),
        .imp_value    (imp_value),
        .imp_ready    (imp_ready),
        .assignment   (assignment),
        .free         (free),
        .apply_valid  (apply_valid),
        .apply_var    (apply_var),
        .conflict     (conflict),
        .conflict_var (conflict_var),
        .busy         (busy),
        .q_count      (q_count)
`ifdef BCP_IMPQ_STATS_EN
        ,
        .stat_applied (stat_applied),
        .stat_dropped (stat_dropped)
`endif
    );

    typedef struct {
        logic       clr;
        logic       vld;
        logic [2:0] v;
        logic       b;
        logic       ready;
        logic [7:0] asg;
        logic [7:0] fr;
        logic       av;
        logic [2:0] avar;
        logic       conf;
        logic [2:0] cvar;
        logic [3:0] cnt;
        int         sa;
        int         sd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic clr, input logic vld, input logic [2:0] v, input logic b);
        clear     = clr;
        imp_valid = vld;
        imp_var   = v;
        imp_value = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_next;
        int max_cnt;

        reset = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_ready",  -1, imp_ready,   1);
        chk("rst_assign", -1, assignment,  8'h00);
        chk("rst_free",   -1, free,        8'hFF);
        chk("rst_av",     -1, apply_valid, 0);
        chk("rst_conf",   -1, conflict,    0);
        chk("rst_cnt",    -1, q_count,     0);
        chk("rst_busy",   -1, busy,        0);

        //            clr vld v  b  rdy asg    fr     av avar conf cvar cnt sa sd
        // duplicate (5,0) twice
        vecs.push_back('{0, 1, 5, 0, 1, 8'h00, 8'hFF, 0, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 1, 5, 0, 1, 8'h00, 8'hDF, 1, 5, 0, 0, 0, 1, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 8'h00, 8'hDF, 0, 0, 0, 0, 0, 1, 1});
        // (3,1): applied one edge after accept
        vecs.push_back('{0, 1, 3, 1, 1, 8'h00, 8'hDF, 0, 0, 0, 0, 1, 1, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 8'h08, 8'hD7, 1, 3, 0, 0, 0, 2, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 8'h08, 8'hD7, 0, 0, 0, 0, 0, 2, 1});
        // (2,1) then (2,0) against pending: conflict, free[2] stays 1
        vecs.push_back('{0, 1, 2, 1, 1, 8'h08, 8'hD7, 0, 0, 0, 0, 1, 2, 1});
        vecs.push_back('{0, 1, 2, 0, 0, 8'h08, 8'hD7, 0, 0, 1, 2, 1, 2, 1});
        vecs.push_back('{0, 0, 0, 0, 0, 8'h08, 8'hD7, 0, 0, 1, 2, 1, 2, 1});
        vecs.push_back('{0, 1, 1, 1, 0, 8'h08, 8'hD7, 0, 0, 1, 2, 1, 2, 1});
        // clear wins over a concurrent implication
        vecs.push_back('{1, 1, 4, 1, 1, 8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 0});
        // assign 6=1, duplicate against assigned, conflict against assigned
        vecs.push_back('{0, 1, 6, 1, 1, 8'h00, 8'hFF, 0, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 8'h40, 8'hBF, 1, 6, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 1, 6, 1, 1, 8'h40, 8'hBF, 0, 0, 0, 0, 0, 1, 1});
        vecs.push_back('{0, 1, 6, 0, 0, 8'h40, 8'hBF, 0, 0, 1, 6, 0, 1, 1});
        vecs.push_back('{1, 0, 0, 0, 1, 8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 0});

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].vld, vecs[i].v, vecs[i].b);
            step();
            $display("row %0d: clr=%0b vld=%0b imp=(%0d,%0b) -> rdy=%0b asg=%02h free=%02h av=%0b/%0d conf=%0b/%0d cnt=%0d",
                     i, vecs[i].clr, vecs[i].vld, vecs[i].v, vecs[i].b, imp_ready, assignment,
                     free, apply_valid, apply_var, conflict, conflict_var, q_count);
            chk("ready",  i, imp_ready,    vecs[i].ready);
            chk("assign", i, assignment,   vecs[i].asg);
            chk("free",   i, free,         vecs[i].fr);
            chk("av",     i, apply_valid,  vecs[i].av);
            if (vecs[i].av) chk("avar", i, apply_var, vecs[i].avar);
            chk("conf",   i, conflict,     vecs[i].conf);
            chk("cvar",   i, conflict_var, vecs[i].cvar);
            chk("cnt",    i, q_count,      vecs[i].cnt);
            chk("busy",   i, busy,         (vecs[i].cnt != 0));
`ifdef BCP_IMPQ_STATS_EN
            chk("stat_applied", i, stat_applied, vecs[i].sa);
            chk("stat_dropped", i, stat_dropped, vecs[i].sd);
`endif
        end
        drive(1'b0, 1'b0, 3'd0, 1'b0);

        // Streaming: 8 distinct variables with valid held high
        exp_next = 0;
        max_cnt  = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, 3'(k), k[0]);
            chk("stream_ready", 100 + k, imp_ready, 1);
            step();
            $display("stream %0d: imp=(%0d,%0b) av=%0b/%0d cnt=%0d", k, k, k[0],
                     apply_valid, apply_var, q_count);
            if (int'(q_count) > max_cnt) max_cnt = int'(q_count);
            if (apply_valid) begin
                chk("stream_order", 100 + k, apply_var, exp_next);
                exp_next++;
            end
        end
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            if (apply_valid) begin
                chk("stream_order", 110 + k, apply_var, exp_next);
                exp_next++;
            end
        end
        chk("stream_applies", 120, exp_next, 8);
        chk("stream_maxcnt",  120, max_cnt, 1);
        chk("stream_assign",  120, assignment, 8'hAA);
        chk("stream_free",    120, free, 8'h00);
`ifdef BCP_IMPQ_STATS_EN
        chk("stream_stat_applied", 120, stat_applied, 8);
`endif

        // Reset with an entry queued: no apply follows
        drive(1'b1, 1'b0, 3'd0, 1'b0);
        step();
        drive(1'b0, 1'b1, 3'd4, 1'b1);
        step();
        chk("prerst_cnt", 130, q_count, 1);
        reset = 1'b1;
        drive(1'b0, 1'b1, 3'd4, 1'b0);
        step();
        $display("reset with entry queued: cnt=%0d busy=%0b av=%0b free=%02h",
                 q_count, busy, apply_valid, free);
        chk("rstq_cnt",  131, q_count, 0);
        chk("rstq_busy", 131, busy, 0);
        chk("rstq_av",   131, apply_valid, 0);
        chk("rstq_free", 131, free, 8'hFF);
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 1'b0);
        step();
        chk("rstq_av2",     132, apply_valid, 0);
        chk("rstq_assign2", 132, assignment, 8'h00);
        chk("rstq_free2",   132, free, 8'hFF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
